// File: rtl/rfg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rfg_bus_arbiter
//   Lets two command sources share one register-file R/W port. Requests are
//   granted round-robin. Each grant produces a one-cycle rfg_write/rfg_read
//   strobe. Write completion, or read data, is returned to the originating
//   master. Reads of unmapped registers, which never assert rfg_read_valid,
//   are terminated by a timeout and flagged with the master's error bit.
//
// Ports
//   clk, resn                    clock, synchronous active-low reset
//   m{0,1}_req                   request, held with its command until ack
//   m{0,1}_write                 1 = write, 0 = read
//   m{0,1}_address               target register address
//   m{0,1}_write_value           write data
//   m{0,1}_ack                   one-cycle completion pulse
//   m{0,1}_error                 read timeout, valid while ack is high
//   m{0,1}_read_value            read data, updated on read ack, then held
//   busy                         high whenever the FSM is not in IDLE
//   rfg_address/rfg_write_value  register-file command, held outside ISSUE
//   rfg_write/rfg_read           one-cycle strobes
//   rfg_read_valid/rfg_read_value  register-file read response
// -----------------------------------------------------------------------------
module rfg_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15   // 1..255
) (
  input  logic              clk,
  input  logic              resn,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_write_value,
  output logic              m0_ack,
  output logic              m0_error,
  output logic [DATA_W-1:0] m0_read_value,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_value,
  output logic              m1_ack,
  output logic              m1_error,
  output logic [DATA_W-1:0] m1_read_value,
  output logic              busy,
  output logic [ADDR_W-1:0] rfg_address,
  output logic [DATA_W-1:0] rfg_write_value,
  output logic              rfg_write,
  output logic              rfg_read,
  input  logic              rfg_read_valid,
  input  logic [DATA_W-1:0] rfg_read_value
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // The counter is cleared on entry to WAIT, so the last waiting cycle sees
  // TIMEOUT-1; this places the timeout ack exactly TIMEOUT cycles after WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               ptr_q;        // index of the master granted last
  logic               gnt_q;        // index of the master owning the transaction
  logic               cmd_write_q;  // latched command type
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant;
  logic               grant_idx;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_address;
  logic [DATA_W-1:0]  sel_write_value;
  logic               resp_vld;
  logic               resp_err;
  logic [DATA_W-1:0]  resp_data;

  // Next-state and response decision.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    grant_idx = ptr_q;
    resp_vld  = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          grant     = 1'b1;
          // On a tie the master not granted last wins.
          grant_idx = (m0_req && m1_req) ? ~ptr_q : m1_req;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (cmd_write_q) begin
          resp_vld = 1'b1;
          state_d  = S_RESP;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rfg_read_valid) begin
          resp_vld  = 1'b1;
          resp_data = rfg_read_value;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_vld  = 1'b1;
          resp_err  = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sel_write       = grant_idx ? m1_write       : m0_write;
  assign sel_address     = grant_idx ? m1_address     : m0_address;
  assign sel_write_value = grant_idx ? m1_write_value : m0_write_value;

  // All outputs are registered: each is loaded on the edge that enters the
  // state in which it must be visible.
  always_ff @(posedge clk) begin
    if (!resn) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q         <= S_IDLE;
      ptr_q           <= 1'b1;  // "m1 granted last" makes m0 win the first tie
      gnt_q           <= 1'b0;
      cmd_write_q     <= 1'b0;
      cnt_q           <= '0;
      busy            <= 1'b0;
      rfg_address     <= '0;
      rfg_write_value <= '0;
      rfg_write       <= 1'b0;
      rfg_read        <= 1'b0;
      m0_ack          <= 1'b0;
      m0_error        <= 1'b0;
      m0_read_value   <= '0;
      m1_ack          <= 1'b0;
      m1_error        <= 1'b0;
      m1_read_value   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= (state_d != S_IDLE);
      rfg_write <= 1'b0;
      rfg_read  <= 1'b0;
      m0_ack    <= 1'b0;
      m0_error  <= 1'b0;
      m1_ack    <= 1'b0;
      m1_error  <= 1'b0;

      if (grant) begin
        ptr_q           <= grant_idx;
        gnt_q           <= grant_idx;
        cmd_write_q     <= sel_write;
        rfg_address     <= sel_address;
        rfg_write_value <= sel_write_value;
        rfg_write       <= sel_write;
        rfg_read        <= ~sel_write;
      end

      if (resp_vld) begin
        if (gnt_q) begin
          m1_ack <= 1'b1;
          if (!cmd_write_q) begin
            m1_read_value <= resp_data;
            m1_error      <= resp_err;
          end
        end else begin
          m0_ack <= 1'b1;
          if (!cmd_write_q) begin
            m0_read_value <= resp_data;
            m0_error      <= resp_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rfg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rfg_bus_arbiter
//   Directed stimulus for rfg_bus_arbiter with a scoreboard: each issued
//   command pushes its expected response (error, read value, ack cycle) into
//   a per-master queue; a negedge monitor pops and compares on every ack.
//   A small register-file model answers reads one cycle after the strobe for
//   addresses below 0x40; higher addresses stay silent. Initial contents are
//   mem[a] = ~a.
// -----------------------------------------------------------------------------
module tb_rfg_bus_arbiter;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic       is_write;
    logic       err;
    logic [7:0] data;
    int         cyc;    // expected ack cycle, -1 = not checked
  } exp_t;

  logic              clk = 1'b0;
  logic              resn = 1'b0;
  logic              m0_req = 1'b0, m1_req = 1'b0;
  logic              m0_write = 1'b0, m1_write = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [DATA_W-1:0] m0_write_value = '0, m1_write_value = '0;
  logic              m0_ack, m1_ack, m0_error, m1_error;
  logic [DATA_W-1:0] m0_read_value, m1_read_value;
  logic              busy;
  logic [ADDR_W-1:0] rfg_address;
  logic [DATA_W-1:0] rfg_write_value;
  logic              rfg_write, rfg_read;
  logic              rfg_read_valid;
  logic [DATA_W-1:0] rfg_read_value;

  logic              rf_valid = 1'b0;
  logic [7:0]        rf_value = '0;
  logic              stray_valid = 1'b0;
  logic [7:0]        stray_value = '0;
  logic [7:0]        mem [256];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   ack_log[$];

  assign rfg_read_valid = rf_valid | stray_valid;
  assign rfg_read_value = stray_valid ? stray_value : rf_value;

  rfg_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .resn           (resn),
    .m0_req         (m0_req),
    .m0_write       (m0_write),
    .m0_address     (m0_address),
    .m0_write_value (m0_write_value),
    .m0_ack         (m0_ack),
    .m0_error       (m0_error),
    .m0_read_value  (m0_read_value),
    .m1_req         (m1_req),
    .m1_write       (m1_write),
    .m1_address     (m1_address),
    .m1_write_value (m1_write_value),
    .m1_ack         (m1_ack),
    .m1_error       (m1_error),
    .m1_read_value  (m1_read_value),
    .busy           (busy),
    .rfg_address    (rfg_address),
    .rfg_write_value(rfg_write_value),
    .rfg_write      (rfg_write),
    .rfg_read       (rfg_read),
    .rfg_read_valid (rfg_read_valid),
    .rfg_read_value (rfg_read_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model.
  initial for (int a = 0; a < 256; a++) mem[a] = ~8'(a);

  always @(posedge clk) begin
    rf_valid <= 1'b0;
    if (rfg_write) mem[rfg_address] <= rfg_write_value;
    if (rfg_read && rfg_address < 8'h40) begin
      rf_valid <= 1'b1;
      rf_value <= mem[rfg_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  task automatic mon(input int m, input logic ack, input logic err, input logic [7:0] rv);
    exp_t e;
    string p;
    p = (m == 0) ? "m0" : "m1";
    if (m == 0 && q0.size() == 0 || m == 1 && q1.size() == 0) begin
      check({p, "_unexpected_ack"}, 32'(ack), 32'd0);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    ack_log.push_back(m);
    check({p, "_error"}, 32'(err), 32'(e.err));
    check({p, "_read_value"}, 32'(rv), 32'(e.data));
    if (e.cyc >= 0) check({p, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (resn) begin
      if (m0_ack === 1'b1) mon(0, m0_ack, m0_error, m0_read_value);
      if (m1_ack === 1'b1) mon(1, m1_ack, m1_error, m1_read_value);
    end
  end

  // Drive a command (called just after a posedge) and optionally push the
  // expected response with its ack latency relative to this cycle.
  task automatic issue(input int m, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic e_err, input logic [7:0] e_data, input int lat, input bit push);
    exp_t e;
    e.is_write = w;
    e.err      = e_err;
    e.data     = e_data;
    e.cyc      = (lat < 0) ? -1 : cyc + lat;
    if (m == 0) begin
      m0_req = 1'b1; m0_write = w; m0_address = a; m0_write_value = d;
      if (push) q0.push_back(e);
    end else begin
      m1_req = 1'b1; m1_write = w; m1_address = a; m1_write_value = d;
      if (push) q1.push_back(e);
    end
  endtask

  // Bounded wait for an ack, then move into the following (IDLE) cycle.
  task automatic wait_ack(input int m, input bit keep);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack === 1'b1) || (m == 1 && m1_ack === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
    check((m == 0) ? "m0_ack_wait" : "m1_ack_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rfg_write"}, 32'(rfg_write), 32'd0);
    check({tag, "_rfg_read"}, 32'(rfg_read), 32'd0);
    check({tag, "_rfg_address"}, 32'(rfg_address), 32'd0);
    check({tag, "_rfg_write_value"}, 32'(rfg_write_value), 32'd0);
    check({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'd0);
    check({tag, "_errors"}, 32'({m0_error, m1_error}), 32'd0);
    check({tag, "_read_values"}, 32'({m0_read_value, m1_read_value}), 32'd0);
  endtask

  // Contention stimulus: 4 reads per master, requests held continuously.
  logic [7:0] c0_addr [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0] c0_exp  [4] = '{8'hEF, 8'hEE, 8'hED, 8'hEC};
  logic [7:0] c1_addr [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
  logic [7:0] c1_exp  [4] = '{8'hDF, 8'hDE, 8'hDD, 8'hDC};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset for 2 cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    resn = 1'b1;

    // Single write, strobe timing checked cycle by cycle.
    issue(0, 1'b1, 8'h01, 8'hA5, 1'b0, 8'h00, 2, 1'b1);
    @(negedge clk);
    check("wr_c0_rfg_write", 32'(rfg_write), 32'd0);
    @(negedge clk);
    check("wr_c1_rfg_write", 32'(rfg_write), 32'd1);
    check("wr_c1_rfg_address", 32'(rfg_address), 32'h01);
    check("wr_c1_rfg_write_value", 32'(rfg_write_value), 32'hA5);
    check("wr_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wr_c2_rfg_write", 32'(rfg_write), 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    check("wr_c3_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // m1 reads back the written register.
    issue(1, 1'b0, 8'h01, 8'h00, 1'b0, 8'hA5, 3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rd_c1_rfg_read", 32'(rfg_read), 32'd1);
    check("rd_c1_rfg_write", 32'(rfg_write), 32'd0);
    wait_ack(1, 1'b0);

    // Contention: grants must alternate starting with m0.
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          issue(0, 1'b0, c0_addr[i], 8'h00, 1'b0, c0_exp[i], -1, 1'b1);
          wait_ack(0, i < 3);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          issue(1, 1'b0, c1_addr[i], 8'h00, 1'b0, c1_exp[i], -1, 1'b1);
          wait_ack(1, i < 3);
        end
      end
    join
    check("contention_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++)
      check($sformatf("contention_order_%0d", i), 32'(ack_log[i]), 32'(i % 2));

    // Timeout on an unmapped address: ack 2 + TIMEOUT cycles after request.
    issue(1, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h00, 2 + TIMEOUT, 1'b1);
    wait_ack(1, 1'b0);
    @(negedge clk);
    check("timeout_error_cleared", 32'(m1_error), 32'd0);
    @(posedge clk); #1;

    // Stray valid while IDLE.
    stray_value = 8'h3C;
    stray_valid = 1'b1;
    @(posedge clk); #1;
    stray_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_m0_rv", 32'(m0_read_value), 32'hEC);
    check("stray_idle_m1_rv", 32'(m1_read_value), 32'h00);
    @(posedge clk); #1;

    // Stray valid during a write (ISSUE and RESP cycles).
    issue(0, 1'b1, 8'h02, 8'h55, 1'b0, 8'hEC, 2, 1'b1);
    @(posedge clk); #1;
    stray_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stray_valid = 1'b0;
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_write_m0_rv", 32'(m0_read_value), 32'hEC);
    check("stray_write_mem", 32'(mem[8'h02]), 32'h55);
    @(posedge clk); #1;

    // Reset during WAIT: the aborted read must never ack.
    issue(0, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h00, -1, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_read_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    resn = 1'b0;
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    resn = 1'b1;

    // Tie right after reset: m0 must win, and both reads complete.
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hEF, 3, 1'b1);
    issue(1, 1'b0, 8'h20, 8'h00, 1'b0, 8'hDF, 7, 1'b1);
    fork
      wait_ack(0, 1'b0);
      wait_ack(1, 1'b0);
    join

    repeat (30) @(negedge clk);
    check("m0_queue_drained", 32'(q0.size()), 32'd0);
    check("m1_queue_drained", 32'(q1.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
